// File: rtl/cpu_pkg.sv
// Shared decode definitions: RV64I opcodes, op_class encoding, width defaults.
// Latency: n/a (types, constants and a pure classification function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int NREG_DEFAULT = 32;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    // Zero doubles as the "illegal" class so a reset output register reads as nothing decoded.
    typedef enum logic [3:0] {
        CLS_ILLEGAL   = 4'd0,
        CLS_OP        = 4'd1,
        CLS_OP_IMM    = 4'd2,
        CLS_OP_32     = 4'd3,
        CLS_OP_IMM_32 = 4'd4,
        CLS_LOAD      = 4'd5,
        CLS_STORE     = 4'd6,
        CLS_BRANCH    = 4'd7,
        CLS_LUI       = 4'd8,
        CLS_AUIPC     = 4'd9,
        CLS_JAL       = 4'd10,
        CLS_JALR      = 4'd11
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] opc);
        op_class_t cls;
        case (opc)
            OPC_OP:        cls = CLS_OP;
            OPC_OP_IMM:    cls = CLS_OP_IMM;
            OPC_OP_32:     cls = CLS_OP_32;
            OPC_OP_IMM_32: cls = CLS_OP_IMM_32;
            OPC_LOAD:      cls = CLS_LOAD;
            OPC_STORE:     cls = CLS_STORE;
            OPC_BRANCH:    cls = CLS_BRANCH;
            OPC_LUI:       cls = CLS_LUI;
            OPC_AUIPC:     cls = CLS_AUIPC;
            OPC_JAL:       cls = CLS_JAL;
            OPC_JALR:      cls = CLS_JALR;
            default:       cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: I/S/B/U/J immediates sign-extended from instr[31] to XLEN; R-type/illegal give 0.
// Latency: purely combinational.
// Backpressure: none (no state).
module imm_gen
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate by format, then sign-extend to the datapath width.
    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: RV64I field decode into a one-entry output register with a busy-register scoreboard.
// Latency: 1 cycle from acceptance to out_valid; writeback clears take effect on hazard one cycle later.
// Backpressure: in_ready drops on a stalled held entry, an operand hazard or flush. Optional STALL_COUNT_EN adds stall_cnt.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            reg_write,
    output logic [3:0]      op_class,
    output logic            illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    op_class_t       dec_cls;
    logic            dec_ill;
    logic            dec_rw;
    logic            use_rs1;
    logic            use_rs2;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] dec_imm;

    logic            out_valid_q, out_valid_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            reg_write_q, reg_write_d;
    logic [3:0]      op_class_q, op_class_d;
    logic            illegal_q, illegal_d;
    logic [NREG-1:0] busy_q, busy_d;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr),
        .imm   (dec_imm)
    );

    // Classify the incoming word, work out which source operands it reads, and derive the handshake.
    always_comb begin
        dec_cls = classify(instr[6:0]);
        dec_ill = (dec_cls == CLS_ILLEGAL);
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (dec_cls)
            CLS_OP, CLS_OP_32, CLS_STORE, CLS_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            CLS_OP_IMM, CLS_OP_IMM_32, CLS_LOAD, CLS_JALR: use_rs1 = 1'b1;
            default: ;
        endcase
        dec_rw   = !dec_ill && (instr[11:7] != 5'd0) &&
                   (dec_cls != CLS_STORE) && (dec_cls != CLS_BRANCH);
        // Scoreboard is read from the register only, so a writeback clear never bypasses into this cycle.
        hazard   = (use_rs1 && busy_q[instr[19:15]]) || (use_rs2 && busy_q[instr[24:20]]);
        in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
        accept   = in_valid && in_ready;
    end

    // Output register: load on acceptance, drain when consumed, hold otherwise; flush empties it.
    always_comb begin
        out_valid_d = out_valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        reg_write_d = reg_write_q;
        op_class_d  = op_class_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rs1_d       = instr[19:15];
            rs2_d       = instr[24:20];
            rd_d        = instr[11:7];
            imm_d       = dec_imm;
            reg_write_d = dec_rw;
            op_class_d  = dec_cls;
            illegal_d   = dec_ill;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard: writeback clears first so a same-index set from acceptance wins; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_valid) busy_d[wb_rd] = 1'b0;
            if (accept && dec_rw) busy_d[instr[11:7]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            op_class_q  <= '0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            reg_write_q <= reg_write_d;
            op_class_q  <= op_class_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign imm       = imm_q;
    assign reg_write = reg_write_q;
    assign op_class  = op_class_q;
    assign illegal   = illegal_q;

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a presented instruction is blocked by an operand hazard, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then randomized traffic against a behavioural model.
// Latency: checks in_ready mid-cycle and registered outputs 1 time unit after each rising edge.
// Backpressure: drives random out_ready / flush / writeback to exercise stalls and hazards.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] instr;
    logic        out_valid, out_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        reg_write;
    logic [3:0]  op_class;
    logic        illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .reg_write (reg_write),
        .op_class  (op_class),
        .illegal   (illegal),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode, written from the ISA field definitions with plain arithmetic.
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm;
        logic        rw;
        logic [3:0]  cls;
        logic        ill;
        logic        u1, u2;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t   d;
        longint v;
        longint u;
        u     = longint'(i);
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd  = i[11:7];
        d.ill = 1'b0;
        d.u1  = 1'b0;
        d.u2  = 1'b0;
        d.cls = 4'd0;
        v     = 0;
        case (i[6:0])
            7'h33: begin d.cls = 4'd1;  d.u1 = 1; d.u2 = 1; end
            7'h13: begin d.cls = 4'd2;  d.u1 = 1; v = u >> 20; if (v >= 2048) v -= 4096; end
            7'h3B: begin d.cls = 4'd3;  d.u1 = 1; d.u2 = 1; end
            7'h1B: begin d.cls = 4'd4;  d.u1 = 1; v = u >> 20; if (v >= 2048) v -= 4096; end
            7'h03: begin d.cls = 4'd5;  d.u1 = 1; v = u >> 20; if (v >= 2048) v -= 4096; end
            7'h23: begin
                d.cls = 4'd6; d.u1 = 1; d.u2 = 1;
                v = (u >> 25) * 32 + ((u >> 7) & 31);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                d.cls = 4'd7; d.u1 = 1; d.u2 = 1;
                v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048 +
                    ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
                if (i[31]) v -= 8192;
            end
            7'h37, 7'h17: begin
                d.cls = (i[6:0] == 7'h37) ? 4'd8 : 4'd9;
                v = u & 64'hFFFF_F000;
                if (i[31]) v -= 64'h1_0000_0000;
            end
            7'h6F: begin
                d.cls = 4'd10;
                v = ((u >> 31) & 1) * (1 << 20) + ((u >> 12) & 255) * 4096 +
                    ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
                if (i[31]) v -= (1 << 21);
            end
            7'h67: begin d.cls = 4'd11; d.u1 = 1; v = u >> 20; if (v >= 2048) v -= 4096; end
            default: d.ill = 1'b1;
        endcase
        d.imm = v;
        d.rw  = !d.ill && (d.rd != 0) && (d.cls != 4'd6) && (d.cls != 4'd7);
        return d;
    endfunction

    logic        m_ov;
    dec_t        m_out;
    logic [31:0] m_busy;
    logic        last_rdy;

    task automatic model_reset();
        m_ov        = 1'b0;
        m_busy      = '0;
        m_out.rs1   = '0;
        m_out.rs2   = '0;
        m_out.rd    = '0;
        m_out.imm   = '0;
        m_out.rw    = 1'b0;
        m_out.cls   = '0;
        m_out.ill   = 1'b0;
        m_out.u1    = 1'b0;
        m_out.u2    = 1'b0;
    endtask

    task automatic compare_outputs();
        chk("out_valid", out_valid, m_ov);
        chk("rs1", rs1, m_out.rs1);
        chk("rs2", rs2, m_out.rs2);
        chk("rd", rd, m_out.rd);
        chk("imm", imm, m_out.imm);
        chk("reg_write", reg_write, m_out.rw);
        chk("op_class", op_class, m_out.cls);
        chk("illegal", illegal, m_out.ill);
        chk("busy", dut.busy_q, m_busy);
    endtask

    // One clock: inputs already driven; check in_ready mid-cycle, advance the model, check after the edge.
    task automatic step();
        dec_t d;
        logic hz, rdy, acc;
        #2;
        d   = ref_decode(instr);
        hz  = (d.u1 && m_busy[d.rs1]) || (d.u2 && m_busy[d.rs2]);
        rdy = (!m_ov || out_ready) && !hz && !flush;
        last_rdy = in_ready;
        if (!rst) chk("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_ov   = 1'b0;
            m_busy = '0;
        end else begin
            if (acc) begin
                m_ov  = 1'b1;
                m_out = d;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (acc && d.rw) m_busy[d.rd] = 1'b1;
            m_busy[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h03, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

    initial begin
        logic [31:0] r;
        int          k;
        rst = 1'b1; in_valid = 0; instr = 0; out_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        chk("rst_imm", imm, 64'd0);
        rst = 1'b0;

        // Accept addi x1,x0,5.
        in_valid = 1; instr = 32'h0050_0093;
        step();
        chk("t1_ov", out_valid, 1); chk("t1_rd", rd, 1); chk("t1_rs1", rs1, 0);
        chk("t1_imm", imm, 64'd5); chk("t1_rw", reg_write, 1); chk("t1_busy1", dut.busy_q[1], 1);

        // add x2,x1,x1 stalls on x1 until its writeback has been registered.
        instr = 32'h0010_8133;
        step(); chk("t2_stall0", last_rdy, 0);
        step(); chk("t2_stall1", last_rdy, 0);
        wb_valid = 1; wb_rd = 5'd1;
        step(); chk("t2_stall_wb", last_rdy, 0);
        wb_valid = 0;
        step(); chk("t2_accept", last_rdy, 1); chk("t2_rd", rd, 2);

        // addi x3,x0,-1.
        instr = 32'hFFF0_0193;
        step(); chk("t3_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF); chk("t3_rd", rd, 3);

        // Retire x2 and x3, then sw x1,8(x2).
        in_valid = 0; wb_valid = 1; wb_rd = 5'd2; step();
        wb_rd = 5'd3; step();
        wb_valid = 0; in_valid = 1; instr = 32'h0011_2423;
        step();
        chk("t4_cls", op_class, 4'd6); chk("t4_imm", imm, 64'd8); chk("t4_rs1", rs1, 2);
        chk("t4_rs2", rs2, 1); chk("t4_rw", reg_write, 0); chk("t4_busy", dut.busy_q, 0);

        // Hold addi x5 under backpressure, then flush.
        instr = 32'h0050_0293;
        step();
        out_ready = 0; instr = 32'h0000_0013;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_hold_rdy", last_rdy, 0); chk("t5_hold_rd", rd, 5); chk("t5_hold_imm", imm, 64'd5);
            chk("t5_hold_ov", out_valid, 1);
        end
        flush = 1; step(); flush = 0;
        chk("t5_flush_ov", out_valid, 0); chk("t5_flush_busy", dut.busy_q, 0);
        out_ready = 1;

        // nop, illegal word, then reset while holding.
        instr = 32'h0000_0013; step(); chk("t6_nop_rw", reg_write, 0);
        instr = 32'hFFFF_FFFF; step(); chk("t6_ill", illegal, 1); chk("t6_ill_rw", reg_write, 0);
        in_valid = 1; out_ready = 0; instr = 32'h0050_0093; step();
        in_valid = 0; step();
        chk("t6_held", out_valid, 1);
        rst = 1; #1;
        chk("t6_rst_ov", out_valid, 0); chk("t6_rst_rd", rd, 0); chk("t6_rst_busy", dut.busy_q, 0);
        model_reset();
        step();
        rst = 0; in_valid = 1; out_ready = 1; instr = 32'h0050_0093;
        step(); chk("t6_post_rst_rdy", last_rdy, 1); chk("t6_post_rst_ov", out_valid, 1);

        // Randomized traffic over a small register window so hazards are frequent.
        for (int n = 0; n < 1500; n++) begin
            r = $urandom();
            k = $urandom_range(0, 11);
            instr = r;
            if (k < 11) instr[6:0] = opcs[k];
            instr[19:15] = 5'($urandom_range(0, 7));
            instr[24:20] = 5'($urandom_range(0, 7));
            instr[11:7]  = 5'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            wb_valid  = ($urandom_range(0, 9) < 3);
            wb_rd     = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 99) < 3);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
